// File: rtl/seq_compare_ctrl_if.sv
// ----------------------------------------------------------------------------
// seq_compare_ctrl_if
//   Request/response bundle between a requesting FSM (master) and the
//   sequential magnitude comparator (slave).
//
//   start  : master -> slave, request a comparison (sampled only when idle)
//   A, B   : master -> slave, WIDTH-bit unsigned operands, latched on accept
//   busy   : slave -> master, comparison in progress
//   done   : slave -> master, one-cycle pulse, result just updated
//   A_lt_B : slave -> master, registered result A < B
//   A_eq_B : slave -> master, registered result A == B
//   A_gt_B : slave -> master, registered result A > B
// ----------------------------------------------------------------------------
interface seq_compare_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             A_lt_B;
  logic             A_eq_B;
  logic             A_gt_B;

  modport master (
    output start, A, B,
    input  busy, done, A_lt_B, A_eq_B, A_gt_B
  );

  modport slave (
    input  start, A, B,
    output busy, done, A_lt_B, A_eq_B, A_gt_B
  );
endinterface

// File: rtl/seq_compare_ctrl.sv
// ----------------------------------------------------------------------------
// seq_compare_ctrl
//   Multi-cycle unsigned magnitude comparator. The latched operands are
//   walked two bits per cycle, most-significant digit first, through one
//   shared 2-bit comparator slice. The walk stops at the first unequal digit
//   and a one-hot registered result is published with a one-cycle done pulse.
//
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : seq_compare_ctrl_if.slave (start/A/B in, busy/done/results out)
//
//   Parameter WIDTH must be even and >= 2; D = WIDTH/2 digits.
//   Latency from accepted start to done is k cycles, k = index (1..D) of the
//   first differing digit from the MSB, or D when the operands are equal.
// ----------------------------------------------------------------------------

// 2-bit unsigned comparator slice: exactly one output is high.
module comparator_2bit (
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  output logic       o_lt,
  output logic       o_eq,
  output logic       o_gt
);
  assign o_lt = (i_a <  i_b);
  assign o_eq = (i_a == i_b);
  assign o_gt = (i_a >  i_b);
endmodule

module seq_compare_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_compare_ctrl_if.slave   bus
);

  localparam int D     = WIDTH / 2;
  localparam int IDX_W = (D > 1) ? $clog2(D) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(D - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDX_W-1:0] r_idx;
  logic             r_lt;
  logic             r_eq;
  logic             r_gt;

  logic [1:0]       w_a_dig;
  logic [1:0]       w_b_dig;
  logic             w_lt;
  logic             w_eq;
  logic             w_gt;
  logic             w_last;
  logic             w_decided;
  logic             w_busy;
  logic             w_done;

  // Digit select: bit offset is 2*idx, built by appending a zero LSB.
  assign w_a_dig = r_a[{r_idx, 1'b0} +: 2];
  assign w_b_dig = r_b[{r_idx, 1'b0} +: 2];

  comparator_2bit u_slice (
    .i_a  (w_a_dig),
    .i_b  (w_b_dig),
    .o_lt (w_lt),
    .o_eq (w_eq),
    .o_gt (w_gt)
  );

  assign w_last    = (r_idx == '0);
  // The walk ends on any unequal digit, or on an equal least-significant digit.
  assign w_decided = w_lt | w_gt | (w_eq & w_last);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (bus.start) w_state_nxt = S_COMPARE;
      S_COMPARE: if (w_decided) w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode: pure functions of the state register, so busy/done are
  // glitch-free and have no path from the inputs.
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_COMPARE: w_busy = 1'b1;
      S_DONE:    w_done = 1'b1;
      default:   ;
    endcase
  end

  // Operand latch, digit index and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_idx <= '0;
      r_lt  <= 1'b0;
      r_eq  <= 1'b0;
      r_gt  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a   <= bus.A;
            r_b   <= bus.B;
            r_idx <= IDX_TOP;
          end
        end
        S_COMPARE: begin
          if (w_decided) begin
            // Slice outputs are mutually exclusive, so the result is one-hot.
            r_lt <= w_lt;
            r_gt <= w_gt;
            r_eq <= w_eq;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
  assign bus.A_lt_B = r_lt;
  assign bus.A_eq_B = r_eq;
  assign bus.A_gt_B = r_gt;

endmodule

// File: tb/tb_seq_compare_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seq_compare_ctrl
//   Directed bench for seq_compare_ctrl at WIDTH=8: a table of operand pairs
//   with hand-computed latency and result, plus hand-written sequences for
//   reset, result hold, start-while-busy and reset mid-comparison.
// ----------------------------------------------------------------------------
module tb_seq_compare_ctrl;

  localparam int WIDTH = 8;
  localparam int D     = WIDTH / 2;

  logic clk;
  logic rst_n;

  seq_compare_ctrl_if #(.WIDTH(WIDTH)) bus ();

  seq_compare_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         k;    // expected cycles from start edge to done
    logic [2:0] res;  // expected {lt, eq, gt}
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] res_now();
    return {bus.A_lt_B, bus.A_eq_B, bus.A_gt_B};
  endfunction

  function automatic logic [4:0] all_out();
    return {bus.busy, bus.done, bus.A_lt_B, bus.A_eq_B, bus.A_gt_B};
  endfunction

  // Issue one request and follow it to completion. Ends #1 after edge k+1,
  // with the DUT back in IDLE.
  task automatic run_cmp(input string name, input logic [7:0] a, input logic [7:0] b,
                         input int exp_k, input logic [2:0] exp_res);
    int  got_k;
    int  c;
    got_k = 0;
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk({name, " busy after start"}, 32'(bus.busy), 32'd1);
    c = 1;
    while (got_k == 0 && c <= D + 2) begin
      @(posedge clk);
      #1;
      if (bus.done) got_k = c;
      else chk({name, " busy while comparing"}, 32'(bus.busy), 32'd1);
      c++;
    end
    chk({name, " latency"}, 32'(got_k), 32'(exp_k));
    chk({name, " busy at done"}, 32'(bus.busy), 32'd0);
    chk({name, " result"}, 32'(res_now()), 32'(exp_res));
    @(posedge clk);
    #1;
    chk({name, " done pulse width"}, 32'(bus.done), 32'd0);
    chk({name, " result after done"}, 32'(res_now()), 32'(exp_res));
  endtask

  initial begin
    int dn_cnt;
    int dn_edge;

    vecs[0] = '{8'hA5, 8'hA5, 4, 3'b010};
    vecs[1] = '{8'hC0, 8'h40, 1, 3'b001};
    vecs[2] = '{8'h00, 8'h80, 1, 3'b100};
    vecs[3] = '{8'h12, 8'h13, 4, 3'b100};
    vecs[4] = '{8'h03, 8'h02, 4, 3'b001};
    vecs[5] = '{8'hFF, 8'hFE, 4, 3'b001};
    vecs[6] = '{8'h7F, 8'hBF, 1, 3'b100};
    vecs[7] = '{8'h34, 8'h31, 3, 3'b001};
    vecs[8] = '{8'h00, 8'h00, 4, 3'b010};

    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    rst_n     = 1'b1;

    // Asynchronous reset, asserted between clock edges
    #13;
    rst_n = 1'b0;
    #1;
    chk("reset outputs immediate", 32'(all_out()), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("idle after reset", 32'(all_out()), 32'd0);
    end

    // Table-driven comparisons
    for (int i = 0; i < 9; i++) begin
      run_cmp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].k, vecs[i].res);
    end

    // LSB-digit decision, then the result must hold through idle cycles
    run_cmp("lsb", 8'h12, 8'h13, 4, 3'b100);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("hold result", 32'(res_now()), 32'(3'b100));
      chk("hold idle", 32'({bus.busy, bus.done}), 32'd0);
    end

    // start pulsed again while busy must be ignored
    @(negedge clk);
    bus.A = 8'h01; bus.B = 8'h02; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    bus.A = 8'hFF; bus.B = 8'h00; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    dn_cnt  = (bus.done) ? 1 : 0;
    dn_edge = (bus.done) ? 1 : 0;
    for (int c = 2; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        dn_cnt++;
        if (dn_edge == 0) dn_edge = c;
      end
      if (c == 4) chk("busy-start result", 32'(res_now()), 32'(3'b100));
    end
    chk("busy-start done count", 32'(dn_cnt), 32'd1);
    chk("busy-start done edge", 32'(dn_edge), 32'd4);
    chk("busy-start final result", 32'(res_now()), 32'(3'b100));

    // Reset in the middle of a comparison
    @(negedge clk);
    bus.A = 8'h55; bus.B = 8'h55; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    dn_cnt = 0;
    for (int c = 1; c <= 2; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) dn_cnt++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid-op reset outputs", 32'(all_out()), 32'd0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) dn_cnt++;
      chk("held in reset", 32'(all_out()), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) dn_cnt++;
    end
    chk("no done for abandoned op", 32'(dn_cnt), 32'd0);
    chk("outputs after abandon", 32'(all_out()), 32'd0);
    run_cmp("post-reset", 8'h03, 8'h02, 4, 3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the bench cannot hang
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_compare_ctrl.md
# seq_compare_ctrl

Multi-cycle magnitude comparator controller. It compares two WIDTH-bit unsigned operands by driving a single `comparator_2bit` slice through the operand digits, two bits per cycle, most-significant digit first. It stops early at the first unequal digit and returns a registered one-hot result with a start/busy/done handshake. It sits between a requesting FSM and the shared 2-bit comparator datapath, trading latency for area.

## Interface

Parameters:
- `WIDTH`, default 8: operand width in bits. Must be even and ≥ 2. The number of digits is D = WIDTH/2.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request a comparison. Sampled only in IDLE.
- `A`  in  WIDTH  operand A, latched when start is accepted
- `B`  in  WIDTH  operand B, latched when start is accepted
- `busy`  out  1  high while in COMPARE
- `done`  out  1  one-cycle pulse: result is valid and newly updated
- `A_lt_B`  out  1  registered result, A < B
- `A_eq_B`  out  1  registered result, A == B
- `A_gt_B`  out  1  registered result, A > B

## Operation

- **Datapath**
  - Internal registers `a_q` and `b_q` (WIDTH each) hold the latched operands.
  - A digit index `idx`, ceil(log2(D)) bits wide (minimum 1), selects the current digit.
  - One `comparator_2bit` instance compares `a_q[2*idx+1:2*idx]` against `b_q[2*idx+1:2*idx]`.
- **State IDLE**
  - busy=0 and done=0.
  - When start=1: latch A and B, set idx=D-1, go to COMPARE.
  - Results keep their previous values.
- **State COMPARE**
  - busy=1. Each clock edge evaluates the digit at idx.
    - Slice reports lt: A_lt_B=1, others 0, go to DONE.
    - Slice reports gt: A_gt_B=1, others 0, go to DONE.
    - Slice reports eq and idx==0: A_eq_B=1, others 0, go to DONE.
    - Slice reports eq and idx>0: idx decrements, stay in COMPARE. Results are unchanged.
- **State DONE**
  - done=1 and busy=0 for exactly one cycle, then go to IDLE unconditionally.
- **Results**
  - The three result bits are exactly one-hot after the first completed comparison.
  - They hold until the next comparison completes.
- **start handling**
  - start is ignored in COMPARE and DONE. It is not queued.
  - Changes on A or B after acceptance have no effect.
- **Reset** (asynchronous, any state, including mid-comparison)
  - state=IDLE, busy=0, done=0, A_lt_B=A_eq_B=A_gt_B=0, idx=0, a_q=b_q=0.
  - A comparison interrupted by reset is abandoned. No done is produced for it.
- **WIDTH=2 (D=1):** every comparison takes exactly one COMPARE cycle.

## Timing

- Edge numbering: start is accepted at edge 0, and busy is high from edge 0.
- Let k (1..D) be the number of digits examined. The first unequal digit from the MSB is number k, or k=D when the operands are equal.
- Results update at edge k.
- done=1 from edge k to edge k+1.
- busy falls at edge k.
- Latency from the start edge to done is k cycles, with a worst case of D.
- The earliest next start is sampled at edge k+2, in IDLE. The minimum issue interval is therefore k+2 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan

All scenarios use WIDTH=8.

- **Reset.** Assert rst_n=0 mid-clock-cycle, asynchronously. Then deassert.
  - Required: all outputs are 0 immediately.
  - Required: busy stays 0 until a start is accepted.
- **Equal operands.** A=8'hA5, B=8'hA5, start pulse.
  - Required: busy for 4 cycles.
  - Required: done at edge 4 with A_eq_B=1, A_lt_B=A_gt_B=0.
- **MSB-digit early exit.** A=8'hC0, B=8'h40.
  - Required: done at edge 1 with A_gt_B=1.
  - Then A=8'h00, B=8'h80. Required: done at edge 1 with A_lt_B=1.
- **LSB-digit decision.** A=8'h12, B=8'h13.
  - Required: 4 compare cycles, then A_lt_B=1.
  - Required: the result holds unchanged through 10 subsequent idle cycles.
- **start while busy.** Start with A=8'h01, B=8'h02. Pulse start again at edge 1 with A=8'hFF, B=8'h00.
  - Required: the second request is ignored.
  - Required: a single done at edge 4 with A_lt_B=1.
- **Reset mid-operation.** Start with A=8'h55, B=8'h55. Assert rst_n=0 at cycle 2.
  - Required: no done. Outputs are 0.
  - Next start with A=8'h03, B=8'h02: done at edge 4 with A_gt_B=1.
